pwm_capture: RTL



---
 rtl/pwm_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures high-time and period of an asynchronous PWM input in clk cycles; one result per period.
// Result valid SYNC_STAGES+1 edges after pwm_in rises; no backpressure, strobes are single-cycle.
module pwm_capture #(
   parameter int B           = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         pwm_in,
   output logic [B-1:0] high_width,
   output logic [B-1:0] period,
   output logic         valid,
   output logic         timeout,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      HIGH      = 2'd2,
      LOW       = 2'd3
   } state_t;

   localparam logic [B-1:0] CNT_MAX = {B{1'b1}};
   localparam logic [B-1:0] CNT_ONE = {{(B-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s, s_d_q, rise, fall;
   logic [B-1:0]           cnt_p_q, cnt_p_d, cnt_h_q, cnt_h_d;
   logic [B-1:0]           cnt_p_inc, cnt_h_inc;
   logic [B-1:0]           high_width_q, high_width_d;
   logic [B-1:0]           period_q, period_d;
   logic                   valid_q, valid_d, timeout_q, timeout_d;
   logic                   tmo_hit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sync_q       <= '0;
         s_d_q        <= 1'b0;
         cnt_p_q      <= '0;
         cnt_h_q      <= '0;
         high_width_q <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_d_q        <= s;
         cnt_p_q      <= cnt_p_d;
         cnt_h_q      <= cnt_h_d;
         high_width_q <= high_width_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d_q;
   assign fall = ~s & s_d_q;

   // Counters saturate so a stuck line can never alias into a short period.
   assign cnt_p_inc = (cnt_p_q == CNT_MAX) ? cnt_p_q : cnt_p_q + CNT_ONE;
   assign cnt_h_inc = (cnt_h_q == CNT_MAX) ? cnt_h_q : cnt_h_q + CNT_ONE;
   assign tmo_hit   = (cnt_p_q == CNT_MAX) && !rise;

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:      state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = HIGH;
            HIGH: begin
               if (tmo_hit)   state_d = WAIT_RISE;
               else if (fall) state_d = LOW;
            end
            LOW: begin
               if (rise)         state_d = HIGH;
               else if (tmo_hit) state_d = WAIT_RISE;
            end
            default:   state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_p_d      = cnt_p_q;
      cnt_h_d      = cnt_h_q;
      high_width_d = high_width_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      timeout_d    = 1'b0;
      if (!en) begin
         cnt_p_d = '0;
         cnt_h_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_p_d = '0;
               cnt_h_d = '0;
            end
            WAIT_RISE: begin
               if (rise) begin
                  cnt_p_d = CNT_ONE;
                  cnt_h_d = CNT_ONE;
               end
            end
            HIGH: begin
               if (tmo_hit) begin
                  timeout_d    = 1'b1;
                  period_d     = '0;
                  high_width_d = '0;
                  cnt_p_d      = '0;
                  cnt_h_d      = '0;
               end else begin
                  cnt_p_d = cnt_p_inc;
                  if (!fall) cnt_h_d = cnt_h_inc;
               end
            end
            LOW: begin
               // The closing rise also opens the next period, so nothing is lost.
               if (rise) begin
                  period_d     = cnt_p_q;
                  high_width_d = cnt_h_q;
                  valid_d      = 1'b1;
                  cnt_p_d      = CNT_ONE;
                  cnt_h_d      = CNT_ONE;
               end else if (tmo_hit) begin
                  timeout_d    = 1'b1;
                  period_d     = '0;
                  high_width_d = '0;
                  cnt_p_d      = '0;
                  cnt_h_d      = '0;
               end else begin
                  cnt_p_d = cnt_p_inc;
               end
            end
            default: begin
               cnt_p_d = '0;
               cnt_h_d = '0;
            end
         endcase
      end
   end

   assign high_width = high_width_q;
   assign period     = period_q;
   assign valid      = valid_q;
   assign timeout    = timeout_q;
   assign busy       = (state_q != IDLE);

endmodule
